// File: rtl/dnn_pkg.sv
// Shared defaults and FSM state encoding for the MAC/requantize datapath.
package dnn_pkg;
   localparam int ACC_W_DEF   = 24;
   localparam int MAX_LEN_DEF = 256;
   localparam int OUT_GAP_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_ROUND,
      S_OUT,
      S_GAP
   } state_e;
endpackage

// File: rtl/requant_sat.sv
// Round-half-up arithmetic right shift of the accumulator, then clamp to int8.
module requant_sat
   import dnn_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic        [3:0]       shift_i,
   output logic        [7:0]       data_o,
   output logic                    sat_o
);
   localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
   localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);

   logic        [ACC_W:0] rnd;
   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] r;

   // One extra bit keeps the rounding add from wrapping near full scale.
   always_comb begin
      rnd = ({{ACC_W{1'b0}}, 1'b1} << shift_i) >> 1;
      sum = $signed({acc_i[ACC_W-1], acc_i}) + $signed(rnd);
      r   = sum >>> shift_i;
      if (r > SAT_HI) begin
         data_o = 8'h7F;
         sat_o  = 1'b1;
      end else if (r < SAT_LO) begin
         data_o = 8'h80;
         sat_o  = 1'b1;
      end else begin
         data_o = r[7:0];
         sat_o  = 1'b0;
      end
   end
endmodule

// File: rtl/mac_requant.sv
// Streaming int8 dot product with bias, requantize to int8, paced output.
//
// state   | meaning
// IDLE    | waiting for first beat of a vector
// ACCUM   | accumulating further beats
// ROUND   | one cycle: requantize the finished sum
// OUT     | valid_out pulse
// GAP     | hold off new input so the downstream stage can drain
module mac_requant
   import dnn_pkg::*;
#(
   parameter int ACC_W   = ACC_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int OUT_GAP = OUT_GAP_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic        last_in,
   input  logic [7:0]  act_in,
   input  logic [7:0]  wgt_in,
   input  logic [15:0] bias_in,
   input  logic [3:0]  shift_in,
   output logic        ready_out,
   output logic        valid_out,
   output logic [7:0]  data_out,
   output logic        sat_out,
   output logic        len_err_out
);
   localparam int CNT_W = $clog2(MAX_LEN + 1);

   state_e                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic        [CNT_W-1:0]  cnt_q, cnt_d;
   logic        [3:0]        shift_q, shift_d;
   logic        [3:0]        gap_q, gap_d;
   logic        [7:0]        data_q, data_d;
   logic                     sat_q, sat_d;
   logic                     valid_q, valid_d;
   logic                     len_err_q, len_err_d;

   logic signed [15:0]       prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic        [CNT_W-1:0]  cnt_inc;
   logic                     accept;
   logic        [7:0]        rq_data;
   logic                     rq_sat;

   assign prod      = $signed(act_in) * $signed(wgt_in);
   assign prod_ext  = ACC_W'(prod);
   assign bias_ext  = ACC_W'($signed(bias_in));
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign ready_out = (state_q == S_IDLE) || (state_q == S_ACCUM);
   assign accept    = valid_in && ready_out;

   requant_sat #(.ACC_W(ACC_W)) u_requant_sat (
      .acc_i   (acc_q),
      .shift_i (shift_q),
      .data_o  (rq_data),
      .sat_o   (rq_sat)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      gap_d     = gap_q;
      data_d    = data_q;
      sat_d     = sat_q;
      valid_d   = 1'b0;
      len_err_d = 1'b0;
      case (state_q)
         S_IDLE: if (accept) begin
            acc_d   = bias_ext + prod_ext;
            cnt_d   = CNT_W'(1);
            shift_d = shift_in;
            state_d = last_in ? S_ROUND : S_ACCUM;
         end
         S_ACCUM: if (accept) begin
            acc_d = acc_q + prod_ext;
            cnt_d = cnt_inc;
            if (last_in) begin
               state_d = S_ROUND;
            end else if (cnt_inc == CNT_W'(MAX_LEN)) begin
               state_d   = S_ROUND;
               len_err_d = 1'b1;
            end
         end
         S_ROUND: begin
            data_d  = rq_data;
            sat_d   = rq_sat;
            valid_d = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: begin
            gap_d   = 4'(OUT_GAP - 1);
            state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_q <= 4'd1) begin
               gap_d   = 4'd0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         shift_q   <= '0;
         gap_q     <= '0;
         data_q    <= '0;
         sat_q     <= 1'b0;
         valid_q   <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         gap_q     <= gap_d;
         data_q    <= data_d;
         sat_q     <= sat_d;
         valid_q   <= valid_d;
         len_err_q <= len_err_d;
      end
   end

   assign valid_out   = valid_q;
   assign data_out    = data_q;
   assign sat_out     = sat_q;
   assign len_err_out = len_err_q;
endmodule
